packet_serializer_tx: RTL and testbench
=======================================

# packet_serializer_tx

Counterpart of the receive-side packet builder. Accepts one `WIDTH`-bit word over a valid/ready handshake and splits it into `NUM_BYTE` bytes, least-significant byte first. Each byte goes out on `txd` as a standard UART frame: 8N1, optionally with even parity. It sits between the memory-mapped TX FIFO read side and the board `txd` pin, so a 32-bit store becomes four serial bytes that the host's receiver reassembles in order.

## Interface
Parameters:
- `CLK_FREQ`, 50 — system clock in MHz.
- `BAUD_RATE`, 9600 — bits per second.
- `NUM_BYTE`, 4 — bytes per word.
- `WIDTH`, `NUM_BYTE*8` — word width; do not override independently.
- localparam `CLKS_PER_BIT` = `CLK_FREQ*1_000_000/BAUD_RATE`, integer-truncated (5208 at defaults); must be ≥ 2.

Ports:
- `clk` input 1 — single system clock, rising edge.
- `reset` input 1 — asynchronous, active-high.
- `packet_data` input `WIDTH` — word to transmit.
- `packet_valid` input 1 — `packet_data` is valid.
- `packet_ready` output 1 — block can accept a word; reset value 1.
- `txd` output 1 — serial line, idle high; registered; reset value 1.
- `busy` output 1 — a word is in flight; reset value 0.
- `byte_done` output 1 — one-cycle pulse on the last cycle of each stop bit; reset value 0.

## Operation
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- Counters:
  - `baud_cnt` counts 0..`CLKS_PER_BIT`-1.
  - `bit_cnt` counts 0..7.
  - `byte_cnt` counts 0..`NUM_BYTE`-1.
  - A shift register of `WIDTH` bits holds the word.
- IDLE:
  - `packet_ready` is 1, `txd` is 1, `busy` is 0.
  - Handshake when `packet_valid & packet_ready` at a rising edge. At that edge: latch `packet_data`, `txd` ← 0, `busy` ← 1, go to START, clear all counters.
- Each state holds `txd` for exactly `CLKS_PER_BIT` cycles. The transition occurs when `baud_cnt` = `CLKS_PER_BIT`-1.
- START → DATA.
- DATA:
  - `txd` = shift[0]; shift right by 1 per bit.
  - After bit 7: go to PARITY if the macro is set, else STOP.
- STOP:
  - `txd` = 1; `byte_done` pulses on its final cycle.
  - If `byte_cnt` < `NUM_BYTE`-1: increment `byte_cnt` and go to START. There is no idle gap between bytes.
  - Otherwise go to IDLE with `packet_ready` ← 1 and `busy` ← 0 on that same edge.
- `packet_ready` is 0 in every state except IDLE. Words offered while busy are held off, never dropped.
- Back-to-back words: if `packet_valid` is high in the first IDLE cycle, the handshake happens there. The gap is one idle-high cycle between the last stop bit and the next start bit.
- `packet_data` is sampled only at the handshake. Later changes have no effect.
- Reset mid-frame: `txd` goes to 1 immediately (asynchronously). The word is discarded and the FSM returns to IDLE.

## Timing
- Handshake to falling edge of `txd`: 1 cycle, since `txd` changes at the handshake edge.
- Frame length: 10×`CLKS_PER_BIT` cycles per byte, or 11× with parity.
- Word length: `NUM_BYTE`×frame.
- `busy` is high from the handshake edge until the end of the last stop bit.
- Next `packet_ready` high comes exactly `NUM_BYTE`×frame cycles after the handshake edge.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: a PARITY state is inserted after bit 7. `txd` = XOR of the 8 data bits (even parity), and the frame is 11 bits.
  - Undefined: no PARITY state and 10-bit frames; no parity logic is synthesized.

## Structure
- Shared header (alongside `system_param.vh`):
  - FSM state encodings.
  - `UART_IDLE_LEVEL` (1'b1).
  - `UART_DATA_BITS` (8).
  - Default `CLK_FREQ`/`BAUD_RATE`; the RX side uses the same values.
- One sub-module, `uart_baud_tick`. It is parameterized by `CLKS_PER_BIT`, is cleared on each state entry, and outputs `bit_end`.

## Test plan
Scenarios use `CLK_FREQ`=1 and `BAUD_RATE`=250000 (`CLKS_PER_BIT`=4).
- Single word: word 0x44332211 with valid pulsed once in IDLE → `txd` shows frames for 0x11, 0x22, 0x33, 0x44, LSB-first, each start=0 and stop=1. There are 160 cycles from the handshake to `packet_ready`=1, and `byte_done` pulses 4 times.
- Bit timing: word 0x000000AA → every bit is held exactly 4 cycles. `txd` falls 1 cycle after the handshake.
- Back-to-back: valid held high with 0x01 then 0xFFFFFFFF → exactly one idle cycle between the last stop bit and the next start bit. The second word is taken only when `packet_ready`=1, and neither word is lost.
- Data change while busy: change `packet_data` mid-word → output unaffected. `packet_ready` stays 0 until 160 cycles have elapsed.
- Reset mid-frame: assert `reset` during bit 3 of byte 1 → `txd`=1 and `busy`=0 within the same cycle, and `packet_ready`=1. The next word transmits cleanly.
- With `UART_TX_PARITY_EN`: byte 0x07 → parity bit 1; byte 0x03 → parity bit 0. The word takes 176 cycles.

Source files
------------

// File: rtl/packet_serializer_tx_pkg.sv
// Shared UART TX definitions: FSM encodings, line constants and default clocking.
// The receive side uses the same CLK_FREQ/BAUD_RATE defaults.
package packet_serializer_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic UART_IDLE_LEVEL    = 1'b1;
    localparam int   UART_DATA_BITS     = 8;
    localparam int   UART_CLK_FREQ_DEF  = 50;
    localparam int   UART_BAUD_RATE_DEF = 9600;

    function automatic int clks_per_bit(input int clk_mhz, input int baud);
        return clk_mhz * 1_000_000 / baud;
    endfunction

endpackage

// File: rtl/packet_serializer_tx_uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Cleared on every FSM state entry so each state holds txd for exactly one bit period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] baud_cnt;

    assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
        end else if (clear || bit_end) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/packet_serializer_tx.sv
// Word-to-UART serializer: sends NUM_BYTE bytes LSB-first as 8N1 frames, even parity
// inserted when UART_TX_PARITY_EN is defined. Accepts a word only while idle.
module packet_serializer_tx
    import packet_serializer_tx_pkg::*;
#(
    parameter int CLK_FREQ  = UART_CLK_FREQ_DEF,
    parameter int BAUD_RATE = UART_BAUD_RATE_DEF,
    parameter int NUM_BYTE  = 4,
    parameter int WIDTH     = NUM_BYTE * 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] packet_data,
    input  logic             packet_valid,
    output logic             packet_ready,
    output logic             txd,
    output logic             busy,
    output logic             byte_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int BW           = (NUM_BYTE > 1) ? $clog2(NUM_BYTE) : 1;

    tx_state_t        state, next_state;
    logic             bit_end;
    logic             txd_d;
    logic [WIDTH-1:0] shift;
    logic [2:0]       bit_cnt;
    logic [BW-1:0]    byte_cnt;
    logic             last_bit, last_byte;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    assign last_bit  = (bit_cnt == 3'(UART_DATA_BITS - 1));
    assign last_byte = (byte_cnt == BW'(NUM_BYTE - 1));

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_tick (
        .clk     (clk),
        .reset   (reset),
        .clear   (next_state != state),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (packet_valid) next_state = ST_START;
            ST_START: if (bit_end) next_state = ST_DATA;
`ifdef UART_TX_PARITY_EN
            ST_DATA:   if (bit_end && last_bit) next_state = ST_PARITY;
            ST_PARITY: if (bit_end) next_state = ST_STOP;
`else
            ST_DATA:   if (bit_end && last_bit) next_state = ST_STOP;
`endif
            ST_STOP:  if (bit_end) next_state = last_byte ? ST_IDLE : ST_START;
            default:  next_state = ST_IDLE;
        endcase
    end

    // txd_d is the line level for the next cycle, so txd changes on the transition edge itself.
    always_comb begin
        txd_d        = txd;
        packet_ready = (state == ST_IDLE);
        busy         = (state != ST_IDLE);
        byte_done    = (state == ST_STOP) && bit_end;
        case (state)
            ST_IDLE:  if (packet_valid) txd_d = 1'b0;
            ST_START: if (bit_end) txd_d = shift[0];
            ST_DATA: begin
                if (bit_end) begin
`ifdef UART_TX_PARITY_EN
                    txd_d = last_bit ? parity_bit : shift[1];
`else
                    txd_d = last_bit ? UART_IDLE_LEVEL : shift[1];
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (bit_end) txd_d = UART_IDLE_LEVEL;
`endif
            ST_STOP:  if (bit_end) txd_d = last_byte ? UART_IDLE_LEVEL : 1'b0;
            default:  txd_d = UART_IDLE_LEVEL;
        endcase
    end

    // After 8 shifts per byte the next byte sits at shift[7:0].
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            txd      <= UART_IDLE_LEVEL;
            shift    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            txd <= txd_d;
            case (state)
                ST_IDLE: begin
                    if (packet_valid) begin
                        shift    <= packet_data;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^shift[7:0];
`endif
                    end
                end
                ST_DATA: begin
                    if (bit_end) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_end && !last_byte) byte_cnt <= byte_cnt + BW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_serializer_tx.sv
// Randomized bench for packet_serializer_tx with a cycle-position reference model of the line.
module tb_packet_serializer_tx;

    localparam int CPB = 4;
    localparam int NB  = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR      = 1'b1;
    localparam int FBITS    = 11;
    localparam int WORD_CYC = 176;
`else
    localparam bit PAR      = 1'b0;
    localparam int FBITS    = 10;
    localparam int WORD_CYC = 160;
`endif
    localparam int FLEN = FBITS * CPB;
    localparam int WLEN = NB * FLEN;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] packet_data;
    logic        packet_valid;
    logic        packet_ready, txd, busy, byte_done;

    always #5 clk = ~clk;

    packet_serializer_tx #(.CLK_FREQ(1), .BAUD_RATE(250000), .NUM_BYTE(NB)) dut (
        .clk          (clk),
        .reset        (reset),
        .packet_data  (packet_data),
        .packet_valid (packet_valid),
        .packet_ready (packet_ready),
        .txd          (txd),
        .busy         (busy),
        .byte_done    (byte_done)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    // Reference model: position within the word since the handshake edge.
    bit          m_act  = 1'b0;
    int          m_t    = 0;
    logic [31:0] m_word = '0;

    function automatic logic exp_txd(input logic [31:0] w, input int t);
        int k, b;
        logic [7:0] by;
        k  = t / FLEN;
        b  = (t % FLEN) / CPB;
        by = 8'(w >> (8 * k));
        if (b == 0) return 1'b0;
        if (b <= 8) return by[b-1];
        if (PAR && b == 9) return ^by;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_act = 1'b0;
        end else if (m_act) begin
            m_t++;
            if (m_t == WLEN) m_act = 1'b0;
        end else if (packet_valid) begin
            m_act  = 1'b1;
            m_t    = 0;
            m_word = packet_data;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("txd",       txd,          m_act ? exp_txd(m_word, m_t) : 1'b1);
            check("busy",      busy,         m_act);
            check("ready",     packet_ready, !m_act);
            check("byte_done", byte_done,    m_act && (m_t % FLEN == FLEN - 1));
        end
    end

    logic rec [0:2047];
    int   cyc, bd;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!packet_ready && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) check({nm, "_timeout"}, 0, 1);
    endtask

    // Returns one time unit after the handshake edge.
    task automatic send(input logic [31:0] d);
        wait_ready("send");
        packet_data  = d;
        packet_valid = 1'b1;
        step();
        packet_valid = 1'b0;
    endtask

    task automatic record;
        int i = 0;
        bd  = 0;
        cyc = -1;
        while (i < 2000) begin
            if (packet_ready) begin
                cyc = i;
                break;
            end
            rec[i] = txd;
            bd += int'(byte_done);
            step();
            i++;
        end
        if (cyc < 0) check("record_timeout", 0, 1);
    endtask

    function automatic logic [7:0] decode(input int k);
        logic [7:0] r;
        for (int b = 0; b < 8; b++) r[b] = rec[k * FLEN + (b + 1) * CPB + 2];
        return r;
    endfunction

    initial begin
        int n, idle;
        reset        = 1'b1;
        packet_valid = 1'b0;
        packet_data  = '0;
        repeat (3) step();
        check("rst_txd",   txd,          1'b1);
        check("rst_ready", packet_ready, 1'b1);
        check("rst_busy",  busy,         1'b0);
        check("rst_bdone", byte_done,    1'b0);
        reset = 1'b0;
        step();

        // Single word
        send(32'h44332211);
        check("fall_after_hs", txd, 1'b0);
        record();
        check("word_cycles", cyc, WORD_CYC);
        check("byte_done_cnt", bd, 4);
        check("byte0", decode(0), 8'h11);
        check("byte1", decode(1), 8'h22);
        check("byte2", decode(2), 8'h33);
        check("byte3", decode(3), 8'h44);
        check("stop0", rec[FLEN - 1], 1'b1);

        // Bit timing
        send(32'h000000AA);
        record();
        check("start_end", rec[3],  1'b0);
        check("bit0_beg",  rec[4],  1'b0);
        check("bit0_end",  rec[7],  1'b0);
        check("bit1_beg",  rec[8],  1'b1);
        check("bit1_end",  rec[11], 1'b1);
        check("bit2_beg",  rec[12], 1'b0);
        check("aa_byte",   decode(0), 8'hAA);

        // Back-to-back with valid held high
        wait_ready("b2b");
        packet_data  = 32'h00000001;
        packet_valid = 1'b1;
        step();
        packet_data = 32'hFFFFFFFF;
        n = 0;
        idle = 0;
        while (n < 2000) begin
            if (packet_ready) begin
                idle++;
                check("gap_txd", txd, 1'b1);
            end else if (idle > 0) begin
                break;
            end
            step();
            n++;
        end
        packet_valid = 1'b0;
        check("gap_cycles", idle, 1);
        check("b2b_start", txd, 1'b0);
        record();
        check("b2b_cycles", cyc, WORD_CYC);
        check("b2b_byte0", decode(0), 8'hFF);
        check("b2b_byte3", decode(3), 8'hFF);

        // Data change while busy
        send(32'hA5C31E77);
        n = 0;
        while (!packet_ready && n < 2000) begin
            if (n == 20) begin
                packet_data  = $urandom;
                packet_valid = 1'b1;
            end
            step();
            n++;
        end
        check("busy_hold_cycles", n, WORD_CYC);
        step();
        packet_valid = 1'b0;

        // Reset during bit 3 of byte 1
        send(32'h12345678);
        repeat (FLEN + 4 * CPB + 1) step();
        check("pre_rst_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_txd",   txd,          1'b1);
        check("mid_rst_busy",  busy,         1'b0);
        check("mid_rst_ready", packet_ready, 1'b1);
        step();
        reset = 1'b0;
        step();
        send(32'hCAFEF00D);
        record();
        check("post_rst_cycles", cyc, WORD_CYC);
        check("post_rst_b0", decode(0), 8'h0D);
        check("post_rst_b1", decode(1), 8'hF0);
        check("post_rst_b2", decode(2), 8'hFE);
        check("post_rst_b3", decode(3), 8'hCA);

`ifdef UART_TX_PARITY_EN
        send(32'h00000307);
        record();
        check("par_07", rec[9 * CPB + 2], 1'b1);
        check("par_03", rec[FLEN + 9 * CPB + 2], 1'b0);
        check("par_cycles", cyc, 176);
`endif

        // Random words with random gaps and data churn while busy
        for (int w = 0; w < 10; w++) begin
            repeat ($urandom_range(0, 3)) step();
            send($urandom);
            repeat ($urandom_range(1, 30)) begin
                step();
                packet_data = $urandom;
            end
        end
        wait_ready("final");
        repeat (3) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
